// File: rtl/pipelined_functional_unit.sv
// Multi-slot ALU functional unit: issued ops count down their per-opcode latency in
// independent slots, then move through a small result FIFO onto the wakeup or LSQ bus.
module pipelined_functional_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int ROB_W     = 6,
  parameter int NUM_SLOTS = 4,
  parameter int OUT_DEPTH = 2,
  parameter int LAT_OR    = 1,
  parameter int LAT_ADD   = 2,
  parameter int LAT_SHIFT = 4,
  parameter int LAT_LUI   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write_enable,
  input  logic [3:0]                       ALUControl,
  input  logic                             ALUSrc,
  input  logic                             is_for_lsq,
  input  logic [XLEN-1:0]                  imm,
  input  logic [XLEN-1:0]                  rs1_value,
  input  logic [XLEN-1:0]                  rs2_value,
  input  logic [TAG_W-1:0]                 tag_to_output,
  input  logic [ROB_W-1:0]                 rob_index,
  output logic                             is_available,
  input  logic                             wakeup_grant,
  input  logic                             lsq_wakeup_grant,
  output logic                             wakeup_active,
  output logic [ROB_W-1:0]                 wakeup_rob_index,
  output logic [TAG_W-1:0]                 wakeup_tag,
  output logic [XLEN-1:0]                  wakeup_value,
  output logic                             lsq_wakeup_active,
  output logic [ROB_W-1:0]                 lsq_wakeup_rob_index,
  output logic [XLEN-1:0]                  lsq_wakeup_value,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   in_flight_count,
  output logic                             error
);

  localparam int LAT_M1  = (LAT_OR > LAT_ADD) ? LAT_OR : LAT_ADD;
  localparam int LAT_M2  = (LAT_SHIFT > LAT_LUI) ? LAT_SHIFT : LAT_LUI;
  localparam int LAT_MAX = (LAT_M1 > LAT_M2) ? LAT_M1 : LAT_M2;
  localparam int CNT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);
  localparam int SIDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int IFC_W   = $clog2(NUM_SLOTS + 1);
  localparam int SH_W    = $clog2(XLEN);

  localparam logic [3:0] OP_NONE0 = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_LUI   = 4'b1100;
  localparam logic [3:0] OP_NONE1 = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
    logic             lsq;
  } result_t;

  logic               r_slot_busy [NUM_SLOTS];
  logic [CNT_W-1:0]   r_slot_cnt  [NUM_SLOTS];
  result_t            r_slot_data [NUM_SLOTS];

  result_t            r_fifo_mem  [OUT_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [FCNT_W-1:0]  r_fifo_cnt;
  logic               r_error;

  logic [XLEN-1:0]    w_rhs;
  logic [SH_W-1:0]    w_shamt;
  logic [XLEN-1:0]    w_result;
  logic [CNT_W-1:0]   w_lat;
  logic               w_illegal;

  logic               w_free_found;
  logic [SIDX_W-1:0]  w_free_idx;
  logic               w_ready_found;
  logic [SIDX_W-1:0]  w_ready_idx;
  logic [IFC_W-1:0]   w_busy_cnt;

  result_t            w_head;
  logic               w_head_valid;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic               w_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_rhs   = ALUSrc ? imm : rs2_value;
  assign w_shamt = w_rhs[SH_W-1:0];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_result  = '1;
    w_lat     = CNT_W'(LAT_LUI);
    w_illegal = 1'b0;
    case (ALUControl)
      OP_OR:  begin w_result = rs1_value | w_rhs;                 w_lat = CNT_W'(LAT_OR);    end
      OP_AND: begin w_result = rs1_value & w_rhs;                 w_lat = CNT_W'(LAT_OR);    end
      OP_XOR: begin w_result = rs1_value ^ w_rhs;                 w_lat = CNT_W'(LAT_OR);    end
      OP_ADD: begin w_result = rs1_value + w_rhs;                 w_lat = CNT_W'(LAT_ADD);   end
      OP_SUB: begin w_result = rs1_value - w_rhs;                 w_lat = CNT_W'(LAT_ADD);   end
      OP_SLL: begin w_result = rs1_value << w_shamt;              w_lat = CNT_W'(LAT_SHIFT); end
      OP_SRL: begin w_result = rs1_value >> w_shamt;              w_lat = CNT_W'(LAT_SHIFT); end
      OP_SRA: begin w_result = $signed(rs1_value) >>> w_shamt;    w_lat = CNT_W'(LAT_SHIFT); end
      OP_LUI: begin w_result = imm;                                                          end
      OP_NONE0, OP_NONE1: ;
      default: w_illegal = 1'b1;
    endcase
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    w_ready_found = 1'b0;
    w_ready_idx   = '0;
    w_busy_cnt    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SIDX_W'(i);
      end
      if (r_slot_busy[i] && (r_slot_cnt[i] == '0)) begin
        w_ready_found = 1'b1;
        w_ready_idx   = SIDX_W'(i);
      end
      w_busy_cnt = w_busy_cnt + IFC_W'(r_slot_busy[i]);
    end
  end

  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_head_valid = (r_fifo_cnt != '0);
  assign w_fifo_full  = (r_fifo_cnt == FCNT_W'(OUT_DEPTH));

  assign wakeup_active     = w_head_valid && !w_head.lsq;
  assign lsq_wakeup_active = w_head_valid &&  w_head.lsq;

  // A FIFO slot vacated by a pop this edge may be refilled by a transfer at the same edge.
  assign w_pop   = (wakeup_active && wakeup_grant) || (lsq_wakeup_active && lsq_wakeup_grant);
  assign w_push  = w_ready_found && (!w_fifo_full || w_pop);
  assign w_issue = write_enable &&  w_free_found;
  assign w_drop  = write_enable && !w_free_found;

  assign is_available    = w_free_found;
  assign in_flight_count = w_busy_cnt;
  assign error           = r_error;

  assign wakeup_value         = w_head_valid ? w_head.value : '0;
  assign wakeup_tag           = w_head_valid ? w_head.tag   : '0;
  assign wakeup_rob_index     = w_head_valid ? w_head.rob   : '0;
  assign lsq_wakeup_value     = w_head_valid ? w_head.value : '0;
  assign lsq_wakeup_rob_index = w_head_valid ? w_head.rob   : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot_busy[i] <= 1'b0;
        r_slot_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_push && (w_ready_idx == SIDX_W'(i))) begin
          r_slot_busy[i] <= 1'b0;
        end else if (w_issue && (w_free_idx == SIDX_W'(i))) begin
          r_slot_busy[i] <= 1'b1;
          r_slot_cnt[i]  <= w_lat;
        end else if (r_slot_busy[i] && (r_slot_cnt[i] != '0)) begin
          r_slot_cnt[i]  <= r_slot_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: payload storage is not reset; valid bits and the FIFO count gate every use of it.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_slot_data[w_free_idx] <= '{value: w_result, tag: tag_to_output,
                                   rob: rob_index, lsq: is_for_lsq};
    end
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= r_slot_data[w_ready_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + FCNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - FCNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      // Sticky: dropped issue or an accepted unknown opcode.
      if (w_drop || (w_issue && w_illegal)) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Self-checking bench for pipelined_functional_unit: opcode vector table, directed
// multi-cycle sequences, and a randomized run against a timestamp-based reference model.
module tb_pipelined_functional_unit;

  localparam int XLEN = 32, TAG_W = 6, ROB_W = 6, NS = 4, OD = 2;
  localparam int LAT_OR = 1, LAT_ADD = 2, LAT_SHIFT = 4, LAT_LUI = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              write_enable;
  logic [3:0]        ALUControl;
  logic              ALUSrc;
  logic              is_for_lsq;
  logic [XLEN-1:0]   imm, rs1_value, rs2_value;
  logic [TAG_W-1:0]  tag_to_output;
  logic [ROB_W-1:0]  rob_index;
  logic              is_available;
  logic              wakeup_grant, lsq_wakeup_grant;
  logic              wakeup_active, lsq_wakeup_active;
  logic [ROB_W-1:0]  wakeup_rob_index, lsq_wakeup_rob_index;
  logic [TAG_W-1:0]  wakeup_tag;
  logic [XLEN-1:0]   wakeup_value, lsq_wakeup_value;
  logic [2:0]        in_flight_count;
  logic              error;

  pipelined_functional_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W), .NUM_SLOTS(NS), .OUT_DEPTH(OD),
    .LAT_OR(LAT_OR), .LAT_ADD(LAT_ADD), .LAT_SHIFT(LAT_SHIFT), .LAT_LUI(LAT_LUI)
  ) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .is_for_lsq(is_for_lsq), .imm(imm), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .tag_to_output(tag_to_output), .rob_index(rob_index),
    .is_available(is_available), .wakeup_grant(wakeup_grant),
    .lsq_wakeup_grant(lsq_wakeup_grant), .wakeup_active(wakeup_active),
    .wakeup_rob_index(wakeup_rob_index), .wakeup_tag(wakeup_tag),
    .wakeup_value(wakeup_value), .lsq_wakeup_active(lsq_wakeup_active),
    .lsq_wakeup_rob_index(lsq_wakeup_rob_index), .lsq_wakeup_value(lsq_wakeup_value),
    .in_flight_count(in_flight_count), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    write_enable = 1'b0; ALUControl = 4'b0000; ALUSrc = 1'b0; is_for_lsq = 1'b0;
    imm = '0; rs1_value = '0; rs2_value = '0; tag_to_output = '0; rob_index = '0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic src, input logic lsq,
                        input logic [5:0] tag, input logic [5:0] rob);
    write_enable = 1'b1; ALUControl = op; rs1_value = a; rs2_value = b; imm = im;
    ALUSrc = src; is_for_lsq = lsq; tag_to_output = tag; rob_index = rob;
  endtask

  task automatic do_reset();
    set_idle();
    wakeup_grant = 1'b0; lsq_wakeup_grant = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] v;
    logic [5:0]  t;
    logic [5:0]  r;
    logic        l;
  } ent_t;

  int    m_cyc = 0;
  logic  m_busy  [NS];
  int    m_ready [NS];
  ent_t  m_slot  [NS];
  ent_t  m_q[$];
  logic  m_err;

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] im);
    case (op)
      4'd1:  return a | b;
      4'd4:  return a & b;
      4'd3:  return a ^ b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd11: return $signed(a) >>> b[4:0];
      4'd12: return im;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd3, 4'd4:  return LAT_OR;
      4'd2, 4'd6:        return LAT_ADD;
      4'd7, 4'd8, 4'd11: return LAT_SHIFT;
      default:           return LAT_LUI;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12, 4'd15};
  endfunction

  // Called just after a posedge, with the inputs that were sampled at that edge.
  task automatic model_step();
    int   f, r;
    logic pop;
    m_cyc++;
    if (!reset) begin
      for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
      m_q.delete();
      m_err = 1'b0;
      return;
    end
    f = -1;
    r = -1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!m_busy[i]) f = i;
      if (m_busy[i] && m_ready[i] <= m_cyc) r = i;
    end
    pop = (m_q.size() > 0) && (m_q[0].l ? lsq_wakeup_grant : wakeup_grant);
    if (pop) void'(m_q.pop_front());
    if (r >= 0 && m_q.size() < OD) begin
      m_q.push_back(m_slot[r]);
      m_busy[r] = 1'b0;
    end
    if (write_enable) begin
      if (f >= 0) begin
        m_busy[f]  = 1'b1;
        m_ready[f] = m_cyc + 1 + ref_lat(ALUControl);
        m_slot[f]  = '{ref_result(ALUControl, rs1_value, ALUSrc ? imm : rs2_value, imm),
                       tag_to_output, rob_index, is_for_lsq};
        if (!ref_legal(ALUControl)) m_err = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic        src;
    logic [31:0] exp_val;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t       vecs [12];
  logic [3:0] legal_ops [11];

  initial begin
    int   seen, n_act, n, peak;
    logic [31:0] got_v, got [4], exp4 [4];
    logic [5:0]  got_t, got_r;
    logic        hv;
    ent_t        h;
    int          nb, ifc;

    vecs[0]  = '{4'b0010, 32'd5,          32'd7,          32'd0,          1'b0, 32'd12,         2, 1'b0};
    vecs[1]  = '{4'b0110, 32'd3,          32'd5,          32'd0,          1'b0, 32'hFFFF_FFFE,  2, 1'b0};
    vecs[2]  = '{4'b0001, 32'd1,          32'd2,          32'd0,          1'b0, 32'd3,          1, 1'b0};
    vecs[3]  = '{4'b0100, 32'h0000_F0F0,  32'h0000_FFFF,  32'h0000_0FF0,  1'b1, 32'h0000_00F0,  1, 1'b0};
    vecs[4]  = '{4'b0011, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'd0,          1'b0, 32'hF0F0_F0F0,  1, 1'b0};
    vecs[5]  = '{4'b0111, 32'd1,          32'h0000_0021,  32'd0,          1'b0, 32'd2,          4, 1'b0};
    vecs[6]  = '{4'b1000, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 32'h0800_0000,  4, 1'b0};
    vecs[7]  = '{4'b1011, 32'h8000_0000,  32'd0,          32'd4,          1'b1, 32'hF800_0000,  4, 1'b0};
    vecs[8]  = '{4'b1100, 32'hDEAD_BEEF,  32'd9,          32'h1234_5000,  1'b0, 32'h1234_5000,  0, 1'b0};
    vecs[9]  = '{4'b0000, 32'd7,          32'd8,          32'd0,          1'b0, 32'hFFFF_FFFF,  0, 1'b0};
    vecs[10] = '{4'b1111, 32'd7,          32'd8,          32'd0,          1'b0, 32'hFFFF_FFFF,  0, 1'b0};
    vecs[11] = '{4'b0101, 32'd7,          32'd8,          32'd0,          1'b0, 32'hFFFF_FFFF,  0, 1'b1};
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12, 4'd15};

    // Reset state.
    do_reset();
    check("rst_active", {62'd0, wakeup_active, lsq_wakeup_active}, 64'd0);
    check("rst_avail",  {63'd0, is_available}, 64'd1);
    check("rst_count",  {61'd0, in_flight_count}, 64'd0);
    check("rst_error",  {63'd0, error}, 64'd0);
    check("rst_data",   {wakeup_value, lsq_wakeup_value}, 64'd0);
    check("rst_ids",    {46'd0, wakeup_tag, wakeup_rob_index, lsq_wakeup_rob_index}, 64'd0);

    // Single op per opcode: latency, value, tag/rob, one-cycle broadcast, error flag.
    for (int i = 0; i < 12; i++) begin
      wakeup_grant = 1'b1;
      set_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].src, 1'b0,
             6'(i + 3), 6'(i + 9));
      tick();
      set_idle();
      seen = -1; n_act = 0; got_v = '0; got_t = '0; got_r = '0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (wakeup_active) begin
          if (seen < 0) begin
            seen = k; got_v = wakeup_value; got_t = wakeup_tag; got_r = wakeup_rob_index;
          end
          n_act++;
        end
      end
      check($sformatf("vec%0d_when", i),  64'(seen), 64'(vecs[i].exp_lat + 1));
      check($sformatf("vec%0d_value", i), {32'd0, got_v}, {32'd0, vecs[i].exp_val});
      check($sformatf("vec%0d_tag", i),   {58'd0, got_t}, 64'(i + 3));
      check($sformatf("vec%0d_rob", i),   {58'd0, got_r}, 64'(i + 9));
      check($sformatf("vec%0d_ncyc", i),  64'(n_act), 64'd1);
      check($sformatf("vec%0d_err", i),   {63'd0, error}, {63'd0, vecs[i].exp_err});
    end
    tick(); tick(); tick();
    check("err_sticky", {63'd0, error}, 64'd1);

    // Short-latency OR overtakes an earlier SRA.
    do_reset();
    wakeup_grant = 1'b1; lsq_wakeup_grant = 1'b1;
    set_op(4'b1011, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 6'd1, 6'd1);
    tick();
    set_op(4'b0001, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 6'd2, 6'd2);
    tick();
    set_idle();
    n = 0; peak = int'(in_flight_count);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (int'(in_flight_count) > peak) peak = int'(in_flight_count);
      if (wakeup_active && n < 4) begin got[n] = wakeup_value; n++; end
    end
    check("ovt_count", 64'(n), 64'd2);
    check("ovt_first", {32'd0, got[0]}, 64'h3);
    check("ovt_second", {32'd0, got[1]}, 64'hF800_0000);
    check("ovt_peak", 64'(peak), 64'd2);

    // Slots full, LSQ bus stalled, overflow issue, then drain.
    do_reset();
    wakeup_grant = 1'b1; lsq_wakeup_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(4'b0111, 32'(i + 1), 32'(i), 32'd0, 1'b0, 1'b1, 6'(i), 6'(i + 20));
      exp4[i] = 32'(i + 1) << i;
      tick();
    end
    check("full_count", {61'd0, in_flight_count}, 64'd4);
    check("full_avail", {63'd0, is_available}, 64'd0);
    check("full_noerr", {63'd0, error}, 64'd0);
    set_op(4'b0001, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 6'd9, 6'd9);
    tick();
    set_idle();
    check("drop_err", {63'd0, error}, 64'd1);
    check("drop_count", {61'd0, in_flight_count}, 64'd4);
    for (int k = 0; k < 6; k++) tick();
    check("stall_act", {62'd0, wakeup_active, lsq_wakeup_active}, 64'd1);
    check("stall_head", {26'd0, lsq_wakeup_rob_index, lsq_wakeup_value}, {26'd0, 6'd20, 32'd1});
    check("stall_count", {61'd0, in_flight_count}, 64'd2);
    check("stall_avail", {63'd0, is_available}, 64'd1);
    lsq_wakeup_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), {31'd0, lsq_wakeup_active, lsq_wakeup_value},
            {31'd0, 1'b1, exp4[k]});
      tick();
    end
    check("drain_done", {61'd0, lsq_wakeup_active, is_available, 1'b0}, 64'b010);
    check("drain_count", {61'd0, in_flight_count}, 64'd0);

    // Zero-latency LUIs waiting behind a full FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp4[i] = 32'hA000 + 32'(i);
      set_op(4'b1100, 32'd0, 32'd0, exp4[i], 1'b0, 1'b1, 6'(i), 6'(i));
      tick();
    end
    set_idle();
    tick(); tick();
    check("lui_wait_count", {61'd0, in_flight_count}, 64'd2);
    check("lui_wait_head", {32'd0, lsq_wakeup_value}, {32'd0, exp4[0]});
    lsq_wakeup_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lui_drain%0d", k), {31'd0, lsq_wakeup_active, lsq_wakeup_value},
            {31'd0, 1'b1, exp4[k]});
      tick();
    end
    check("lui_done", {61'd0, in_flight_count}, 64'd0);

    // Reset with three ops in flight and one queued.
    do_reset();
    set_op(4'b1100, 32'd0, 32'd0, 32'h55, 1'b0, 1'b0, 6'd1, 6'd1);
    tick();
    set_op(4'b0111, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 6'd2, 6'd2);
    tick(); tick(); tick();
    set_idle();
    check("pre_rst_count", {61'd0, in_flight_count}, 64'd3);
    check("pre_rst_head", {31'd0, wakeup_active, wakeup_value}, {31'd0, 1'b1, 32'h55});
    reset = 1'b0;
    tick();
    check("mid_rst_active", {62'd0, wakeup_active, lsq_wakeup_active}, 64'd0);
    check("mid_rst_count", {61'd0, in_flight_count}, 64'd0);
    check("mid_rst_avail", {63'd0, is_available}, 64'd1);
    check("mid_rst_value", {32'd0, wakeup_value}, 64'd0);
    reset = 1'b1; wakeup_grant = 1'b1; lsq_wakeup_grant = 1'b1;
    n_act = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wakeup_active || lsq_wakeup_active) n_act++;
    end
    check("post_rst_quiet", 64'(n_act), 64'd0);

    // Randomized run against the reference model, with resets at the start and midway.
    for (int k = 0; k < 600; k++) begin
      reset            = (k < 2 || k == 300) ? 1'b0 : 1'b1;
      write_enable     = ($urandom_range(0, 99) < 60);
      ALUControl       = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15))
                                                      : legal_ops[$urandom_range(0, 10)];
      ALUSrc           = 1'($urandom_range(0, 1));
      is_for_lsq       = 1'($urandom_range(0, 1));
      imm              = $urandom();
      rs1_value        = $urandom();
      rs2_value        = $urandom();
      tag_to_output    = 6'($urandom_range(0, 63));
      rob_index        = 6'($urandom_range(0, 63));
      wakeup_grant     = ($urandom_range(0, 99) < 50);
      lsq_wakeup_grant = ($urandom_range(0, 99) < 50);
      @(posedge clk);
      model_step();
      #1;
      hv = (m_q.size() > 0);
      h  = hv ? m_q[0] : '0;
      nb = 0;
      for (int i = 0; i < NS; i++) if (m_busy[i]) nb++;
      ifc = nb;
      check($sformatf("rnd%0d_wk", k),
            {19'd0, wakeup_active, wakeup_tag, wakeup_rob_index, wakeup_value},
            {19'd0, hv && !h.l, h.t, h.r, h.v});
      check($sformatf("rnd%0d_lsq", k),
            {25'd0, lsq_wakeup_active, lsq_wakeup_rob_index, lsq_wakeup_value},
            {25'd0, hv && h.l, h.r, h.v});
      check($sformatf("rnd%0d_status", k),
            {59'd0, is_available, in_flight_count, error},
            {59'd0, (nb < NS), 3'(ifc), m_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
